mux_stim_seq: RTL and testbench

- Synthesizable, table-driven stimulus sequencer for N-input mux DUTs.
- Replaces hard-coded delay-based initial-block generators with a programmable step table. Each step has a select value, an optional data update to one channel, and a dwell time.
- Runs single-shot or looped, with start/stop control and a done pulse, so one bench and one FPGA harness can drive any mux width or channel count.

---
 rtl/mux_stim_seq.sv | 191 +++++++++++++++++++
 tb/tb_mux_stim_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_stim_seq.sv
// rtl/mux_stim_seq.sv - table-driven stimulus sequencer for N-input mux DUTs
//
// Plays a programmable step table into a mux DUT. Each step drives a select
// value, optionally updates one channel's data word, then holds for dwell+1
// cycles. Runs single-shot (done pulse at the end) or looped.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cfg_we..cfg_dwell  step-table write port, accepted only while idle
//   cfg_last        index of the final step, captured on an accepted start
//   start, stop     run request (level) and abort request
//   loop_en         wrap to step 0 after the final step
//   busy, done      running flag, one-cycle normal-completion pulse
//   step_strobe     one-cycle pulse on the first cycle of each applied step
//   step_idx        index of the step currently applied
//   out_sel         select drive to the DUT
//   out_data        channel k at bits [k*DATA_W +: DATA_W]

module mux_stim_seq #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [SEL_W-1:0]         cfg_sel,
  input  logic [SEL_W-1:0]         cfg_ch,
  input  logic                     cfg_upd,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic [DWELL_W-1:0]       cfg_dwell,
  input  logic [AW-1:0]            cfg_last,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic                     busy,
  output logic                     done,
  output logic                     step_strobe,
  output logic [AW-1:0]            step_idx,
  output logic [SEL_W-1:0]         out_sel,
  output logic [NUM_CH*DATA_W-1:0] out_data
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  // Step table
  logic [SEL_W-1:0]   tbl_sel   [DEPTH];
  logic [SEL_W-1:0]   tbl_ch    [DEPTH];
  logic               tbl_upd   [DEPTH];
  logic [DATA_W-1:0]  tbl_data  [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];

  // Run-time registers
  logic [AW-1:0]             last_q;
  logic [AW-1:0]             step_idx_q;
  logic [DWELL_W-1:0]        cnt_q;
  logic [SEL_W-1:0]          out_sel_q;
  logic [NUM_CH*DATA_W-1:0]  out_data_q;
  logic                      done_q;
  logic                      strobe_q;

  // Next-state decode results
  logic          start_ok;
  logic          apply_en;
  logic [AW-1:0] apply_idx;
  logic          finish;

  // Entry read for the step being applied
  logic               wr_en;
  logic               byp;
  logic [SEL_W-1:0]   rd_sel;
  logic [SEL_W-1:0]   rd_ch;
  logic               rd_upd;
  logic [DATA_W-1:0]  rd_data;
  logic [DWELL_W-1:0] rd_dwell;

  assign wr_en    = cfg_we && (state_q == IDLE);
  assign start_ok = (state_q == IDLE) && start && !stop;

  // A write landing on the same edge as start must reach step 0, so the
  // write port is forwarded around the table when it targets the read entry.
  assign byp      = wr_en && (cfg_addr == apply_idx);
  assign rd_sel   = byp ? cfg_sel   : tbl_sel[apply_idx];
  assign rd_ch    = byp ? cfg_ch    : tbl_ch[apply_idx];
  assign rd_upd   = byp ? cfg_upd   : tbl_upd[apply_idx];
  assign rd_data  = byp ? cfg_data  : tbl_data[apply_idx];
  assign rd_dwell = byp ? cfg_dwell : tbl_dwell[apply_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_sel[i]   <= '0;
        tbl_ch[i]    <= '0;
        tbl_upd[i]   <= 1'b0;
        tbl_data[i]  <= '0;
        tbl_dwell[i] <= '0;
      end
    end else if (wr_en) begin
      tbl_sel[cfg_addr]   <= cfg_sel;
      tbl_ch[cfg_addr]    <= cfg_ch;
      tbl_upd[cfg_addr]   <= cfg_upd;
      tbl_data[cfg_addr]  <= cfg_data;
      tbl_dwell[cfg_addr] <= cfg_dwell;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; stop outranks advance and loop
  always_comb begin
    state_d   = state_q;
    apply_en  = 1'b0;
    apply_idx = '0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d  = RUN;
          apply_en = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (step_idx_q != last_q) begin
            apply_en  = 1'b1;
            apply_idx = step_idx_q + AW'(1);
          end else if (loop_en) begin
            apply_en  = 1'b1;
          end else begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered step application and dwell count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      step_idx_q <= '0;
      cnt_q      <= '0;
      out_sel_q  <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      done_q   <= finish;
      strobe_q <= apply_en;
      if (start_ok) last_q <= cfg_last;
      if (apply_en) begin
        step_idx_q <= apply_idx;
        out_sel_q  <= rd_sel;
        cnt_q      <= rd_dwell;
        if (rd_upd) begin
          // Channel codes beyond NUM_CH-1 match nothing and update nothing
          for (int k = 0; k < NUM_CH; k++) begin
            if (rd_ch == k[SEL_W-1:0]) out_data_q[k*DATA_W +: DATA_W] <= rd_data;
          end
        end
      end else if (state_q == RUN && cnt_q != '0) begin
        cnt_q <= cnt_q - DWELL_W'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    busy        = (state_q == RUN);
    done        = done_q;
    step_strobe = strobe_q;
    step_idx    = step_idx_q;
    out_sel     = out_sel_q;
    out_data    = out_data_q;
  end

endmodule

// File: tb/tb_mux_stim_seq.sv
// tb/tb_mux_stim_seq.sv - directed bench for mux_stim_seq

module tb_mux_stim_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic        cfg_sel;
  logic        cfg_ch;
  logic        cfg_upd;
  logic [15:0] cfg_data;
  logic [7:0]  cfg_dwell;
  logic [3:0]  cfg_last;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic        busy;
  logic        done;
  logic        step_strobe;
  logic [3:0]  step_idx;
  logic        out_sel;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  mux_stim_seq #(.NUM_CH(2), .DATA_W(16), .DEPTH(16), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_upd(cfg_upd), .cfg_data(cfg_data),
    .cfg_dwell(cfg_dwell), .cfg_last(cfg_last), .start(start), .stop(stop),
    .loop_en(loop_en), .busy(busy), .done(done), .step_strobe(step_strobe),
    .step_idx(step_idx), .out_sel(out_sel), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic s, input logic c,
                             input logic u, input logic [15:0] d, input logic [7:0] w);
    cfg_addr = a; cfg_sel = s; cfg_ch = c; cfg_upd = u; cfg_data = d; cfg_dwell = w;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wait_done: got no done within %0d cycles, want done", bound); end
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", step_strobe); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", step_idx); end
    checks++; if (out_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %0b want 0", out_sel); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    rst_n = 1'b1;
    tick();
    // start together with stop while idle is ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_stop_busy: got %0b want 0", busy); end
    checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL start_with_stop_strobe: got %0b want 0", step_strobe); end
  endtask

  task automatic test_dwell_timing;
    logic [3:0] ei;
    write_entry(4'd0, 1'b1, 1'b0, 1'b1, 16'h1111, 8'd2);
    write_entry(4'd1, 1'b0, 1'b1, 1'b1, 16'h2222, 8'd0);
    write_entry(4'd2, 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'd4);
    cfg_last = 4'd2; loop_en = 1'b0;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      ei = (c <= 3) ? 4'd0 : (c == 4) ? 4'd1 : 4'd2;
      checks++; if (step_strobe !== (c == 1 || c == 4 || c == 5))
        begin errors++; $display("FAIL dwell_strobe c%0d: got %0b want %0b", c, step_strobe, (c == 1 || c == 4 || c == 5)); end
      checks++; if (busy !== (c >= 1 && c <= 9))
        begin errors++; $display("FAIL dwell_busy c%0d: got %0b want %0b", c, busy, (c >= 1 && c <= 9)); end
      checks++; if (done !== (c == 10))
        begin errors++; $display("FAIL dwell_done c%0d: got %0b want %0b", c, done, (c == 10)); end
      checks++; if (step_idx !== ei)
        begin errors++; $display("FAIL dwell_idx c%0d: got %0d want %0d", c, step_idx, ei); end
      if (c == 2) start = 1'b1;   // start while busy must be ignored
      if (c == 3) start = 1'b0;
      tick();
    end
    checks++; if (out_data !== {16'h2222, 16'h1111}) begin errors++; $display("FAIL dwell_data: got %h want 22221111", out_data); end
    checks++; if (out_sel !== 1'b1) begin errors++; $display("FAIL dwell_sel: got %0b want 1", out_sel); end
  endtask

  task automatic test_legacy;
    logic [3:0] es;
    int n;
    int done_c;
    es = 4'b1101;
    n = 0; done_c = -1;
    write_entry(4'd0, 1'b1, 1'b0, 1'b1, 16'd4096, 8'd99);
    write_entry(4'd1, 1'b0, 1'b1, 1'b1, 16'd1234, 8'd99);
    write_entry(4'd2, 1'b1, 1'b0, 1'b0, 16'd0,    8'd99);
    write_entry(4'd3, 1'b1, 1'b0, 1'b1, 16'd2048, 8'd99);
    cfg_last = 4'd3; loop_en = 1'b0;
    pulse_start();
    for (int c = 1; c <= 500 && done_c < 0; c++) begin
      if (done) done_c = c;
      if (step_strobe) begin
        checks++;
        if (n > 3) begin errors++; $display("FAIL legacy_extra_strobe: got strobe %0d at c%0d want 4 total", n, c); end
        else begin
          if (c !== 1 + 100 * n) begin errors++; $display("FAIL legacy_strobe_cycle %0d: got c%0d want c%0d", n, c, 1 + 100 * n); end
          checks++;
          if (out_sel !== es[n]) begin errors++; $display("FAIL legacy_sel %0d: got %0b want %0b", n, out_sel, es[n]); end
        end
        n++;
      end
      if (done_c < 0) tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL legacy_strobe_count: got %0d want 4", n); end
    checks++; if (done_c !== 401) begin errors++; $display("FAIL legacy_done_cycle: got %0d want 401", done_c); end
    checks++; if (out_data !== {16'd1234, 16'd2048}) begin errors++; $display("FAIL legacy_data: got %h want %h", out_data, {16'd1234, 16'd2048}); end
    tick();
  endtask

  task automatic test_loop;
    logic [3:0] ei;
    write_entry(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'd1);
    write_entry(4'd1, 1'b1, 1'b0, 1'b0, 16'h0, 8'd2);
    cfg_last = 4'd1; loop_en = 1'b1;
    pulse_start();
    for (int c = 1; c <= 20; c++) begin
      ei = (((c - 1) % 5) < 2) ? 4'd0 : 4'd1;
      checks++; if (step_idx !== ei) begin errors++; $display("FAIL loop_idx c%0d: got %0d want %0d", c, step_idx, ei); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done c%0d: got %0b want 0", c, done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy c%0d: got %0b want 1", c, busy); end
      if (c == 18) loop_en = 1'b0;
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL loop_exit_done: got %0b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_exit_busy: got %0b want 0", busy); end
    checks++; if (out_sel !== 1'b1) begin errors++; $display("FAIL loop_exit_sel: got %0b want 1", out_sel); end
    checks++; if (step_idx !== 4'd1) begin errors++; $display("FAIL loop_exit_idx: got %0d want 1", step_idx); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done_pulse_width: got %0b want 0", done); end
  endtask

  task automatic test_full_table;
    logic [3:0] ei;
    for (int i = 0; i < 16; i++) write_entry(4'(i), 1'(i), 1'b0, 1'b0, 16'h0, 8'd0);
    cfg_last = 4'd15; loop_en = 1'b1;
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      ei = 4'((c - 1) % 16);
      checks++; if (step_idx !== ei) begin errors++; $display("FAIL full_idx c%0d: got %0d want %0d", c, step_idx, ei); end
      checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL full_strobe c%0d: got %0b want 1", c, step_strobe); end
      tick();
    end
    stop = 1'b1; loop_en = 1'b0;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_stop_busy: got %0b want 0", busy); end
  endtask

  task automatic test_stop;
    write_entry(4'd0, 1'b0, 1'b0, 1'b1, 16'h0A0A, 8'd3);
    write_entry(4'd1, 1'b0, 1'b0, 1'b0, 16'h0,    8'd3);
    write_entry(4'd2, 1'b1, 1'b0, 1'b0, 16'h0,    8'd3);
    write_entry(4'd3, 1'b0, 1'b0, 1'b1, 16'hDEAD, 8'd3);
    cfg_last = 4'd3; loop_en = 1'b0;
    pulse_start();
    for (int c = 1; c < 10; c++) tick();
    checks++; if (step_idx !== 4'd2) begin errors++; $display("FAIL stop_pre_idx: got %0d want 2", step_idx); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b want 0", busy); end
    checks++; if (step_idx !== 4'd2) begin errors++; $display("FAIL stop_idx: got %0d want 2", step_idx); end
    checks++; if (out_sel !== 1'b1) begin errors++; $display("FAIL stop_sel: got %0b want 1", out_sel); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (done !== 1'b0 || step_strobe !== 1'b0)
        begin errors++; $display("FAIL stop_quiet c%0d: got done=%0b strobe=%0b want 0 0", c, done, step_strobe); end
      tick();
    end
    checks++; if (out_data[15:0] !== 16'h0A0A) begin errors++; $display("FAIL stop_no_step3: got %h want 0a0a", out_data[15:0]); end
    pulse_start();
    checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL replay_strobe: got %0b want 1", step_strobe); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL replay_idx: got %0d want 0", step_idx); end
    checks++; if (out_sel !== 1'b0) begin errors++; $display("FAIL replay_sel: got %0b want 0", out_sel); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_locked_table;
    write_entry(4'd0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'd1);
    write_entry(4'd1, 1'b1, 1'b0, 1'b1, 16'h5555, 8'd1);
    cfg_last = 4'd1; loop_en = 1'b0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL locked_busy: got %0b want 1", busy); end
    write_entry(4'd0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 8'd1);
    wait_done(20);
    pulse_start();
    checks++; if (out_data[15:0] !== 16'h1234) begin errors++; $display("FAIL locked_data: got %h want 1234", out_data[15:0]); end
    checks++; if (out_sel !== 1'b0) begin errors++; $display("FAIL locked_sel: got %0b want 0", out_sel); end
    wait_done(20);
    cfg_addr = 4'd0; cfg_sel = 1'b1; cfg_ch = 1'b0; cfg_upd = 1'b1; cfg_data = 16'hBEEF; cfg_dwell = 8'd1;
    cfg_we = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    checks++; if (out_data[15:0] !== 16'hBEEF) begin errors++; $display("FAIL same_cycle_data: got %h want beef", out_data[15:0]); end
    checks++; if (out_sel !== 1'b1) begin errors++; $display("FAIL same_cycle_sel: got %0b want 1", out_sel); end
    wait_done(20);
  endtask

  task automatic test_async_reset;
    write_entry(4'd0, 1'b1, 1'b1, 1'b1, 16'h7777, 8'd50);
    cfg_last = 4'd0; loop_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 5; c++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %0b want 0", busy); end
    checks++; if (out_sel !== 1'b0) begin errors++; $display("FAIL areset_sel: got %0b want 0", out_sel); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL areset_data: got %h want 0", out_data); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL areset_idx: got %0d want 0", step_idx); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %0b want 0", done); end
    rst_n = 1'b1;
    tick();
    pulse_start();
    checks++; if (step_strobe !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL blank_start: got strobe=%0b busy=%0b want 1 1", step_strobe, busy); end
    checks++; if (out_sel !== 1'b0) begin errors++; $display("FAIL blank_sel: got %0b want 0", out_sel); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL blank_data: got %h want 0", out_data); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL single_step_done: got done=%0b busy=%0b want 1 0", done, busy); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = 1'b0; cfg_ch = 1'b0;
    cfg_upd = 1'b0; cfg_data = '0; cfg_dwell = '0; cfg_last = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    test_reset();
    test_dwell_timing();
    test_legacy();
    test_loop();
    test_full_table();
    test_stop();
    test_locked_table();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
